instr_collate: RTL and testbench

//  Sits between wavefront fetch and decode_core.
//  - Takes one 32-bit instruction word per cycle, tagged with a wavefront id.
//  - Presents a registered 64-bit collated word, collate_done and the wfid to decode.
//  - When decode answers collate_required=1, parks the first word in a per-wavefront

---
 rtl/instr_collate_pkg.sv | 17 +
 rtl/instr_collate_slot_array.sv | 85 ++++++++
 rtl/instr_collate.sv | 138 +++++++++++++
 tb/tb_instr_collate.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_collate_pkg.sv
//------------------------------------------------------------------------------
// Module : instr_collate_pkg
// Brief  : Shared constants for the instruction collation block.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package instr_collate_pkg;

    localparam int          CFG_NUM_WF = 40;
    localparam int          CFG_WFID_W = 6;
    localparam int          SLOT_W     = 32;
    localparam logic [31:0] PC_STEP    = 32'd4;

endpackage

`default_nettype wire

// File: rtl/instr_collate_slot_array.sv
//------------------------------------------------------------------------------
// Module : instr_collate_slot_array
// Brief  : Per-wavefront parked first words plus their pending bits.
//          Macro COLLATE_PC_CHECK_EN adds a stored PC per slot.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_collate_slot_array
    import instr_collate_pkg::*;
#(
    parameter int NUM_WF = CFG_NUM_WF,
    parameter int WFID_W = CFG_WFID_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WFID_W-1:0] wr_addr,
    input  logic [SLOT_W-1:0] wr_data,
`ifdef COLLATE_PC_CHECK_EN
    input  logic [31:0]       wr_pc,
    output logic [31:0]       rd_pc,
`endif
    input  logic [WFID_W-1:0] rd_addr,
    output logic [SLOT_W-1:0] rd_data,
    output logic              rd_pending,
    input  logic              hit_clr,
    input  logic [WFID_W-1:0] hit_addr,
    input  logic              flush_clr,
    input  logic [WFID_W-1:0] flush_addr,
    output logic [NUM_WF-1:0] pending_mask
);

    localparam logic [NUM_WF-1:0] c_one    = NUM_WF'(1);
    localparam logic [WFID_W-1:0] c_num_wf = WFID_W'(NUM_WF);

    logic [SLOT_W-1:0] r_slot [NUM_WF];
    logic [NUM_WF-1:0] r_pending;
    logic [NUM_WF-1:0] w_set;
    logic [NUM_WF-1:0] w_hit;
    logic [NUM_WF-1:0] w_flush;
    logic              w_rd_ok;

    // Out-of-range ids shift the one-hot bit off the top and become no-ops.
    always_comb begin
        w_set   = wr_en     ? (c_one << wr_addr)    : '0;
        w_hit   = hit_clr   ? (c_one << hit_addr)   : '0;
        w_flush = flush_clr ? (c_one << flush_addr) : '0;
        w_rd_ok = (rd_addr < c_num_wf);
    end

    // Clears are applied after the set, so flush beats a same-cycle capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending | w_set) & ~w_hit & ~w_flush;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr < c_num_wf)) begin
            r_slot[wr_addr] <= wr_data;
        end
    end

    assign rd_data      = w_rd_ok ? r_slot[rd_addr] : '0;
    assign rd_pending   = w_rd_ok ? r_pending[rd_addr] : 1'b0;
    assign pending_mask = r_pending;

`ifdef COLLATE_PC_CHECK_EN
    logic [31:0] r_pc [NUM_WF];

    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr < c_num_wf)) begin
            r_pc[wr_addr] <= wr_pc;
        end
    end

    assign rd_pc = w_rd_ok ? r_pc[rd_addr] : '0;
`endif

endmodule

`default_nettype wire

// File: rtl/instr_collate.sv
//------------------------------------------------------------------------------
// Module : instr_collate
// Brief  : Merges two-word instructions per wavefront ahead of decode.
//          Macro COLLATE_PC_CHECK_EN enables the second-word PC check.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_collate
    import instr_collate_pkg::*;
#(
    parameter int NUM_WF = CFG_NUM_WF,
    parameter int WFID_W = CFG_WFID_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_valid,
    input  logic [WFID_W-1:0]   fetch_wfid,
    input  logic [31:0]         fetch_instr,
    input  logic [31:0]         fetch_pc,
    input  logic                flush_valid,
    input  logic [WFID_W-1:0]   flush_wfid,
    input  logic                collate_required,
    output logic [2*SLOT_W-1:0] collated_instr,
    output logic                collate_done,
    output logic [WFID_W-1:0]   collate_wfid,
    output logic                collate_valid,
    output logic                decode_valid,
    output logic [NUM_WF-1:0]   pending_mask,
    output logic                collate_pc_err
);

    logic [2*SLOT_W-1:0] r_collated_instr;
    logic                r_collate_done;
    logic [WFID_W-1:0]   r_collate_wfid;
    logic                r_collate_valid;

    logic                w_capture;
    logic                w_cap_hit;
    logic                w_flush_hit;
    logic                w_pend_eff;
    logic                w_hit;
    logic                w_rd_pending;
    logic [SLOT_W-1:0]   w_rd_data;
    logic [SLOT_W-1:0]   w_first_word;

    always_comb begin
        w_capture    = r_collate_valid & ~r_collate_done & collate_required;
        w_cap_hit    = w_capture && (r_collate_wfid == fetch_wfid);
        w_flush_hit  = flush_valid && (flush_wfid == fetch_wfid);
        // A word captured this cycle is bypassed straight into the merge.
        w_pend_eff   = (w_rd_pending | w_cap_hit) & ~w_flush_hit;
        w_hit        = fetch_valid & w_pend_eff;
        w_first_word = w_cap_hit ? r_collated_instr[SLOT_W-1:0] : w_rd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_collated_instr <= '0;
            r_collate_done   <= 1'b0;
            r_collate_wfid   <= '0;
            r_collate_valid  <= 1'b0;
        end else begin
            r_collate_valid <= fetch_valid;
            if (w_hit) begin
                r_collated_instr <= {fetch_instr, w_first_word};
                r_collate_done   <= 1'b1;
                r_collate_wfid   <= fetch_wfid;
            end else if (fetch_valid) begin
                r_collated_instr <= {{SLOT_W{1'b0}}, fetch_instr};
                r_collate_done   <= 1'b0;
                r_collate_wfid   <= fetch_wfid;
            end else begin
                r_collate_done   <= 1'b0;
            end
        end
    end

`ifdef COLLATE_PC_CHECK_EN
    logic [31:0] r_collate_pc;
    logic [31:0] w_rd_pc;
    logic [31:0] w_first_pc;
    logic        r_pc_err;

    assign w_first_pc = w_cap_hit ? r_collate_pc : w_rd_pc;

    // r_collate_pc tracks the PC of whatever word sits in the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_collate_pc <= '0;
            r_pc_err     <= 1'b0;
        end else begin
            if (fetch_valid) begin
                r_collate_pc <= fetch_pc;
            end
            r_pc_err <= w_hit && (fetch_pc != (w_first_pc + PC_STEP));
        end
    end

    assign collate_pc_err = r_pc_err;
`else
    logic w_unused_pc;
    assign w_unused_pc    = ^fetch_pc;
    assign collate_pc_err = 1'b0;
`endif

    instr_collate_slot_array #(
        .NUM_WF (NUM_WF),
        .WFID_W (WFID_W)
    ) u_slot_array (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (w_capture),
        .wr_addr      (r_collate_wfid),
        .wr_data      (r_collated_instr[SLOT_W-1:0]),
`ifdef COLLATE_PC_CHECK_EN
        .wr_pc        (r_collate_pc),
        .rd_pc        (w_rd_pc),
`endif
        .rd_addr      (fetch_wfid),
        .rd_data      (w_rd_data),
        .rd_pending   (w_rd_pending),
        .hit_clr      (w_hit),
        .hit_addr     (fetch_wfid),
        .flush_clr    (flush_valid),
        .flush_addr   (flush_wfid),
        .pending_mask (pending_mask)
    );

    assign collated_instr = r_collated_instr;
    assign collate_done   = r_collate_done;
    assign collate_wfid   = r_collate_wfid;
    assign collate_valid  = r_collate_valid;
    assign decode_valid   = r_collate_valid & ~collate_required;

endmodule

`default_nettype wire

// File: tb/tb_instr_collate.sv
//------------------------------------------------------------------------------
// Module : tb_instr_collate
// Brief  : Directed self-checking bench for instr_collate.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_instr_collate;

    localparam int NUM_WF = 40;
    localparam int WFID_W = 6;

    logic              clk;
    logic              rst;
    logic              fetch_valid;
    logic [WFID_W-1:0] fetch_wfid;
    logic [31:0]       fetch_instr;
    logic [31:0]       fetch_pc;
    logic              flush_valid;
    logic [WFID_W-1:0] flush_wfid;
    logic              collate_required;
    logic [63:0]       collated_instr;
    logic              collate_done;
    logic [WFID_W-1:0] collate_wfid;
    logic              collate_valid;
    logic              decode_valid;
    logic [NUM_WF-1:0] pending_mask;
    logic              collate_pc_err;

    int n_vec = 0;
    int n_err = 0;

    instr_collate #(
        .NUM_WF (NUM_WF),
        .WFID_W (WFID_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_valid      (fetch_valid),
        .fetch_wfid       (fetch_wfid),
        .fetch_instr      (fetch_instr),
        .fetch_pc         (fetch_pc),
        .flush_valid      (flush_valid),
        .flush_wfid       (flush_wfid),
        .collate_required (collate_required),
        .collated_instr   (collated_instr),
        .collate_done     (collate_done),
        .collate_wfid     (collate_wfid),
        .collate_valid    (collate_valid),
        .decode_valid     (decode_valid),
        .pending_mask     (pending_mask),
        .collate_pc_err   (collate_pc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers only: inputs change at the falling edge.
    task automatic fetch(input logic [WFID_W-1:0] wf, input logic [31:0] instr,
                         input logic [31:0] pc);
        fetch_valid = 1'b1;
        fetch_wfid  = wf;
        fetch_instr = instr;
        fetch_pc    = pc;
    endtask

    task automatic idle();
        fetch_valid = 1'b0;
        fetch_wfid  = '0;
        fetch_instr = '0;
        fetch_pc    = '0;
        flush_valid = 1'b0;
        flush_wfid  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        collate_required = 1'b0;
        idle();
        fetch(6'd2, 32'hFFFF_FFFF, 32'h0);
        repeat (2) @(negedge clk);
        n_vec++; if (collated_instr !== 64'h0) begin n_err++; $display("FAIL reset_instr got %h want 0", collated_instr); end
        n_vec++; if (collate_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", collate_valid); end
        n_vec++; if (collate_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", collate_done); end
        n_vec++; if (collate_wfid !== 6'd0) begin n_err++; $display("FAIL reset_wfid got %0d want 0", collate_wfid); end
        n_vec++; if (pending_mask !== 40'h0) begin n_err++; $display("FAIL reset_pending got %h want 0", pending_mask); end
        n_vec++; if (collate_pc_err !== 1'b0) begin n_err++; $display("FAIL reset_pc_err got %b want 0", collate_pc_err); end
        rst = 1'b0;
        idle();
        @(negedge clk);
    endtask

    task automatic test_sop2();
        fetch(6'd3, 32'h8000_0000, 32'h40);
        @(negedge clk);
        idle();
        #1;
        n_vec++; if (collated_instr !== 64'h0000_0000_8000_0000) begin n_err++; $display("FAIL sop2_instr got %h want 0000000080000000", collated_instr); end
        n_vec++; if (collate_done !== 1'b0) begin n_err++; $display("FAIL sop2_done got %b want 0", collate_done); end
        n_vec++; if (decode_valid !== 1'b1) begin n_err++; $display("FAIL sop2_decode_valid got %b want 1", decode_valid); end
        n_vec++; if (collate_wfid !== 6'd3) begin n_err++; $display("FAIL sop2_wfid got %0d want 3", collate_wfid); end
        n_vec++; if (pending_mask !== 40'h0) begin n_err++; $display("FAIL sop2_pending got %h want 0", pending_mask); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        fetch(6'd5, 32'hD200_0000, 32'h100);
        @(negedge clk);
        collate_required = 1'b1;
        fetch(6'd5, 32'h0000_0001, 32'h104);
        #1;
        n_vec++; if (decode_valid !== 1'b0) begin n_err++; $display("FAIL b2b_decode_valid got %b want 0", decode_valid); end
        @(negedge clk);
        collate_required = 1'b0;
        idle();
        #1;
        n_vec++; if (collated_instr !== 64'h0000_0001_D200_0000) begin n_err++; $display("FAIL b2b_instr got %h want 00000001d2000000", collated_instr); end
        n_vec++; if (collate_done !== 1'b1) begin n_err++; $display("FAIL b2b_done got %b want 1", collate_done); end
        n_vec++; if (collate_wfid !== 6'd5) begin n_err++; $display("FAIL b2b_wfid got %0d want 5", collate_wfid); end
        n_vec++; if (pending_mask[5] !== 1'b0) begin n_err++; $display("FAIL b2b_pending5 got %b want 0", pending_mask[5]); end
        n_vec++; if (collate_pc_err !== 1'b0) begin n_err++; $display("FAIL b2b_pc_err got %b want 0", collate_pc_err); end
        @(negedge clk);
        n_vec++; if (collate_done !== 1'b0) begin n_err++; $display("FAIL b2b_done_drop got %b want 0", collate_done); end
    endtask

    task automatic test_interleave();
        fetch(6'd1, 32'hD800_0010, 32'h200);
        @(negedge clk);
        collate_required = 1'b1;
        fetch(6'd2, 32'h8000_0000, 32'h300);
        @(negedge clk);
        collate_required = 1'b0;
        n_vec++; if (collated_instr !== 64'h0000_0000_8000_0000) begin n_err++; $display("FAIL il_wf2_instr got %h want 0000000080000000", collated_instr); end
        n_vec++; if (collate_done !== 1'b0 || collate_wfid !== 6'd2) begin n_err++; $display("FAIL il_wf2_tag got done=%b wfid=%0d want done=0 wfid=2", collate_done, collate_wfid); end
        n_vec++; if (pending_mask !== 40'h2) begin n_err++; $display("FAIL il_pending got %h want 0000000002", pending_mask); end
        fetch(6'd1, 32'h0102_0304, 32'h204);
        @(negedge clk);
        idle();
        n_vec++; if (collated_instr !== 64'h0102_0304_D800_0010) begin n_err++; $display("FAIL il_wf1_instr got %h want 01020304d8000010", collated_instr); end
        n_vec++; if (collate_done !== 1'b1 || collate_wfid !== 6'd1) begin n_err++; $display("FAIL il_wf1_tag got done=%b wfid=%0d want done=1 wfid=1", collate_done, collate_wfid); end
        n_vec++; if (pending_mask !== 40'h0) begin n_err++; $display("FAIL il_pending_end got %h want 0", pending_mask); end
        @(negedge clk);
    endtask

    task automatic test_flush();
        fetch(6'd7, 32'hAAAA_0001, 32'h400);
        @(negedge clk);
        collate_required = 1'b1;
        idle();
        @(negedge clk);
        collate_required = 1'b0;
        n_vec++; if (pending_mask !== 40'h80) begin n_err++; $display("FAIL fl_parked got %h want 0000000080", pending_mask); end
        fetch(6'd7, 32'hBBBB_0002, 32'h404);
        flush_valid = 1'b1;
        flush_wfid  = 6'd7;
        @(negedge clk);
        idle();
        n_vec++; if (collated_instr !== 64'h0000_0000_BBBB_0002) begin n_err++; $display("FAIL fl_instr got %h want 00000000bbbb0002", collated_instr); end
        n_vec++; if (collate_done !== 1'b0) begin n_err++; $display("FAIL fl_done got %b want 0", collate_done); end
        n_vec++; if (pending_mask !== 40'h0) begin n_err++; $display("FAIL fl_pending got %h want 0", pending_mask); end
        @(negedge clk);
    endtask

    task automatic test_flush_capture();
        // Flush on the capture cycle wins; the next word is a first word.
        fetch(6'd4, 32'hCCCC_0001, 32'h500);
        @(negedge clk);
        collate_required = 1'b1;
        idle();
        flush_valid = 1'b1;
        flush_wfid  = 6'd4;
        @(negedge clk);
        collate_required = 1'b0;
        idle();
        n_vec++; if (pending_mask !== 40'h0) begin n_err++; $display("FAIL fc_pending got %h want 0", pending_mask); end
        fetch(6'd4, 32'hCCCC_0002, 32'h504);
        @(negedge clk);
        idle();
        n_vec++; if (collated_instr !== 64'h0000_0000_CCCC_0002 || collate_done !== 1'b0) begin n_err++; $display("FAIL fc_instr got %h done=%b want 00000000cccc0002 done=0", collated_instr, collate_done); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        fetch(6'd9, 32'hD000_0009, 32'h600);
        @(negedge clk);
        collate_required = 1'b1;
        idle();
        @(negedge clk);
        collate_required = 1'b0;
        n_vec++; if (pending_mask !== 40'h200) begin n_err++; $display("FAIL rm_parked got %h want 0000000200", pending_mask); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++; if (collated_instr !== 64'h0 || collate_valid !== 1'b0 || collate_done !== 1'b0 || collate_wfid !== 6'd0) begin n_err++; $display("FAIL rm_outputs got instr=%h valid=%b done=%b wfid=%0d want all 0", collated_instr, collate_valid, collate_done, collate_wfid); end
        n_vec++; if (pending_mask !== 40'h0) begin n_err++; $display("FAIL rm_pending got %h want 0", pending_mask); end
        fetch(6'd9, 32'h1234_5678, 32'h604);
        @(negedge clk);
        idle();
        n_vec++; if (collated_instr !== 64'h0000_0000_1234_5678 || collate_done !== 1'b0) begin n_err++; $display("FAIL rm_first got %h done=%b want 0000000012345678 done=0", collated_instr, collate_done); end
        @(negedge clk);
    endtask

`ifdef COLLATE_PC_CHECK_EN
    task automatic test_pc_check();
        fetch(6'd11, 32'hD200_1111, 32'h100);
        @(negedge clk);
        collate_required = 1'b1;
        fetch(6'd11, 32'h0000_2222, 32'h108);
        @(negedge clk);
        collate_required = 1'b0;
        idle();
        n_vec++; if (collate_pc_err !== 1'b1 || collate_done !== 1'b1) begin n_err++; $display("FAIL pc_bad got err=%b done=%b want err=1 done=1", collate_pc_err, collate_done); end
        @(negedge clk);
        n_vec++; if (collate_pc_err !== 1'b0) begin n_err++; $display("FAIL pc_pulse got %b want 0", collate_pc_err); end
        fetch(6'd12, 32'hD200_3333, 32'h100);
        @(negedge clk);
        collate_required = 1'b1;
        idle();
        @(negedge clk);
        collate_required = 1'b0;
        fetch(6'd12, 32'h0000_4444, 32'h104);
        @(negedge clk);
        idle();
        n_vec++; if (collate_pc_err !== 1'b0 || collate_done !== 1'b1) begin n_err++; $display("FAIL pc_good got err=%b done=%b want err=0 done=1", collate_pc_err, collate_done); end
        @(negedge clk);
    endtask
`endif

    initial begin
        rst = 1'b1;
        collate_required = 1'b0;
        idle();
        test_reset();
        test_sop2();
        test_back_to_back();
        test_interleave();
        test_flush();
        test_flush_capture();
        test_reset_mid();
`ifdef COLLATE_PC_CHECK_EN
        test_pc_check();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
